// File: rtl/ft_link_pkg.sv
// ft_link_pkg: shared FT link frame constants, state encoding and header packing
package ft_link_pkg;

    typedef enum logic [2:0] {IDLE, SYNC, HDR, PAY, CHK} stateT;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int MAX_PAYLOAD = 64;
    localparam int LEN_W = $clog2(MAX_PAYLOAD);
    localparam int HDR_ID_MSB = 7;
    localparam int HDR_ID_LSB = 6;
    localparam int HDR_LEN_MSB = 5;
    localparam int HDR_LEN_LSB = 0;

    function automatic logic [7:0] makeHdr(input logic [1:0] id, input logic [LEN_W-1:0] len);
        logic [7:0] h;
        h = '0;
        h[HDR_ID_MSB:HDR_ID_LSB] = id;
        h[HDR_LEN_MSB:HDR_LEN_LSB] = len;
        return h;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting just after the last grant
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] iReq,
    input  logic [1:0]   iLast,
    output logic [N-1:0] oGrant,
    output logic [1:0]   oIdx
);

    int cand;
    logic found;

    always_comb begin
        oGrant = '0;
        oIdx = '0;
        found = 1'b0;
        cand = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(iLast) + k) % N;
            if (!found && iReq[cand]) begin
                found = 1'b1;
                oIdx = 2'(cand);
                oGrant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ft_tx_frame_arbiter.sv
// ft_tx_frame_arbiter: round-robin framer sharing the FT2232H TX FIFO among requesters
module ft_tx_frame_arbiter
    import ft_link_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int CNT_W = 16
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic [NUM_REQ-1:0]   iReq,
    input  logic [NUM_REQ*6-1:0] iReqLen,
    input  logic [NUM_REQ-1:0]   iValid,
    input  logic [NUM_REQ*8-1:0] iData,
    output logic [NUM_REQ-1:0]   oReady,
    output logic [NUM_REQ-1:0]   oGrant,
    output logic                 oTxWrEn,
    output logic [7:0]           oTxData,
    input  logic                 iTxWrFull,
    output logic                 oBusy,
    output logic [CNT_W-1:0]     oFrameCnt
);

    stateT state, nextState;
    logic [1:0] sel, lastSel, arbIdx;
    logic [LEN_W-1:0] len, cnt, lenSel;
    logic [7:0] chk, dataSel, hdrByte;
    logic [NUM_REQ-1:0] arbGrant;
    logic anyReq, wrOk, payXfer;
    logic [3:0] reqPad, validPad, readyPad, grantPad;
    logic [23:0] lenPad;
    logic [31:0] dataPad;

    // Pad per-requester buses to four slots so 2-bit selects index them cleanly
    assign reqPad = 4'(iReq);
    assign validPad = 4'(iValid);
    assign lenPad = 24'(iReqLen);
    assign dataPad = 32'(iData);

    rr_arbiter #(.N(NUM_REQ)) uArb (
        .iReq  (iReq),
        .iLast (lastSel),
        .oGrant(arbGrant),
        .oIdx  (arbIdx)
    );

    assign anyReq = |arbGrant;
    assign wrOk = !iTxWrFull;
    assign lenSel = arbIdx == 2'd0 ? lenPad[5:0] : arbIdx == 2'd1 ? lenPad[11:6] :
                    arbIdx == 2'd2 ? lenPad[17:12] : lenPad[23:18];
    assign dataSel = sel == 2'd0 ? dataPad[7:0] : sel == 2'd1 ? dataPad[15:8] :
                     sel == 2'd2 ? dataPad[23:16] : dataPad[31:24];
    assign hdrByte = makeHdr(sel, len);
    assign payXfer = state == PAY && validPad[sel] && wrOk;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state <= IDLE;
        else state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: nextState = anyReq ? SYNC : IDLE;
            SYNC: nextState = !reqPad[sel] ? IDLE : wrOk ? HDR : SYNC;
            HDR:  nextState = wrOk ? PAY : HDR;
            PAY:  nextState = payXfer && cnt == '0 ? CHK : PAY;
            CHK:  nextState = wrOk ? IDLE : CHK;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            sel <= '0;
            len <= '0;
            cnt <= '0;
            chk <= '0;
            lastSel <= 2'(NUM_REQ - 1);
            oFrameCnt <= '0;
        end else begin
            if (state == IDLE && anyReq) begin
                sel <= arbIdx;
                len <= lenSel;
            end
            if (state == HDR && wrOk) begin
                cnt <= len;
                chk <= hdrByte;
            end
            if (payXfer) begin
                cnt <= cnt - LEN_W'(1);
                chk <= chk ^ dataSel;
            end
            if (state == CHK && wrOk) begin
                oFrameCnt <= oFrameCnt + CNT_W'(1);
                lastSel <= sel;
            end
        end
    end

    always_comb begin
        oTxWrEn = wrOk && ((state == SYNC && reqPad[sel]) || state == HDR || state == CHK ||
                           (state == PAY && validPad[sel]));
        oTxData = state == SYNC ? SYNC_BYTE : state == HDR ? hdrByte :
                  state == PAY ? dataSel : state == CHK ? chk : 8'h00;
        readyPad = (state == PAY && wrOk) ? 4'b0001 << sel : 4'b0000;
        grantPad = (state == HDR && wrOk) ? 4'b0001 << sel : 4'b0000;
        oBusy = state != IDLE;
    end

    assign oReady = readyPad[NUM_REQ-1:0];
    assign oGrant = grantPad[NUM_REQ-1:0];

endmodule

// File: tb/tb_ft_tx_frame_arbiter.sv
// tb_ft_tx_frame_arbiter: scoreboard bench for the TX frame arbiter
module tb_ft_tx_frame_arbiter;

    logic        iClk = 1'b0;
    logic        iRst;
    logic [1:0]  iReq;
    logic [11:0] iReqLen;
    logic [1:0]  iValid;
    logic [15:0] iData;
    logic [1:0]  oReady, oGrant;
    logic        oTxWrEn;
    logic [7:0]  oTxData;
    logic        iTxWrFull;
    logic        oBusy;
    logic [15:0] oFrameCnt;

    ft_tx_frame_arbiter #(.NUM_REQ(2), .SYNC_BYTE(8'hA5), .CNT_W(16)) dut (
        .iClk(iClk), .iRst(iRst), .iReq(iReq), .iReqLen(iReqLen), .iValid(iValid),
        .iData(iData), .oReady(oReady), .oGrant(oGrant), .oTxWrEn(oTxWrEn),
        .oTxData(oTxData), .iTxWrFull(iTxWrFull), .oBusy(oBusy), .oFrameCnt(oFrameCnt)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int errors = 0;
    int wrCnt = 0;
    int reqCnt[2];
    int grantSeen[2];
    int grantCnt[2];
    logic [1:0] pulse;
    logic [7:0] expQ[$];
    logic [7:0] srcQ0[$];
    logic [7:0] srcQ1[$];
    bit patQ[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sendFrame(input int id, input int n, input logic [7:0] b0, b1, b2, b3);
        logic [7:0] b[4];
        logic [7:0] hdr, sum;
        b = '{b0, b1, b2, b3};
        hdr = {2'(id), 6'(n - 1)};
        sum = hdr;
        iReqLen[6*id +: 6] = 6'(n - 1);
        expQ.push_back(8'hA5);
        expQ.push_back(hdr);
        for (int i = 0; i < n; i++) begin
            if (id == 0) srcQ0.push_back(b[i]);
            else srcQ1.push_back(b[i]);
            expQ.push_back(b[i]);
            sum = sum ^ b[i];
        end
        expQ.push_back(sum);
        reqCnt[id]++;
    endtask

    task automatic waitDone(input string tag);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge iClk);
            #1;
            done = expQ.size() == 0 && !oBusy;
        end
        if (!done) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic waitWr(input int target);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge iClk);
            #1;
            done = wrCnt >= target;
        end
        if (!done) check("wr_timeout", 0, 1);
    endtask

    task automatic pulseReset();
        @(negedge iClk);
        iRst = 1'b1;
        repeat (2) @(negedge iClk);
        iRst = 1'b0;
    endtask

    // Requester model: consumes accepted bytes, drops iReq once granted
    initial begin
        logic [1:0] fire, g;
        logic rdy0;
        iValid = '0;
        iData = '0;
        iReq = '0;
        forever begin
            @(negedge iClk);
            fire = iValid & oReady;
            g = oGrant;
            rdy0 = oReady[0];
            @(posedge iClk);
            #1;
            if (fire[0] && srcQ0.size() > 0) void'(srcQ0.pop_front());
            if (fire[1] && srcQ1.size() > 0) void'(srcQ1.pop_front());
            if (rdy0 && patQ.size() > 0) void'(patQ.pop_front());
            if (g[0]) grantSeen[0]++;
            if (g[1]) grantSeen[1]++;
            iReq[0] = reqCnt[0] != grantSeen[0] || pulse[0];
            iReq[1] = reqCnt[1] != grantSeen[1] || pulse[1];
            iValid[0] = srcQ0.size() > 0 && (patQ.size() == 0 || patQ[0]);
            iValid[1] = srcQ1.size() > 0;
            iData[7:0] = srcQ0.size() > 0 ? srcQ0[0] : 8'h00;
            iData[15:8] = srcQ1.size() > 0 ? srcQ1[0] : 8'h00;
        end
    end

    // FIFO-side monitor and scoreboard
    initial begin
        forever begin
            @(negedge iClk);
            if (!iRst) begin
                if (iTxWrFull) begin
                    check("wr_while_full", 32'(oTxWrEn), 0);
                    check("rdy_while_full", 32'(oReady), 0);
                end
                if (oTxWrEn && !iTxWrFull) begin
                    wrCnt++;
                    if (expQ.size() == 0) check("unexpected_wr", 32'(oTxData), 32'hDEAD);
                    else check("tx_byte", 32'(oTxData), 32'(expQ.pop_front()));
                end
                if (oGrant[0]) grantCnt[0]++;
                if (oGrant[1]) grantCnt[1]++;
            end
        end
    end

    initial begin
        int w, fc;
        iRst = 1'b1;
        iTxWrFull = 1'b0;
        iReqLen = '0;
        pulse = '0;
        reqCnt = '{0, 0};
        grantSeen = '{0, 0};
        grantCnt = '{0, 0};
        repeat (3) @(posedge iClk);
        #1;
        check("rst_busy", 32'(oBusy), 0);
        check("rst_wren", 32'(oTxWrEn), 0);
        check("rst_ready", 32'(oReady), 0);
        check("rst_grant", 32'(oGrant), 0);
        check("rst_data", 32'(oTxData), 0);
        check("rst_cnt", 32'(oFrameCnt), 0);
        @(negedge iClk);
        iRst = 1'b0;

        sendFrame(0, 3, 8'h11, 8'h22, 8'h33, 8'h00);
        waitDone("single");
        check("single_cnt", 32'(oFrameCnt), 1);
        check("single_grant", 32'(grantCnt[0]), 1);

        pulseReset();
        check("rr_cnt_rst", 32'(oFrameCnt), 0);
        sendFrame(0, 3, 8'h01, 8'h02, 8'h03, 8'h00);
        sendFrame(1, 1, 8'h5A, 8'h00, 8'h00, 8'h00);
        sendFrame(0, 3, 8'h04, 8'h05, 8'h06, 8'h00);
        sendFrame(1, 1, 8'h77, 8'h00, 8'h00, 8'h00);
        waitDone("rr");
        check("rr_cnt", 32'(oFrameCnt), 4);
        check("rr_grant1", 32'(grantCnt[1]), 2);

        w = wrCnt;
        sendFrame(0, 4, 8'hC0, 8'hC1, 8'hC2, 8'hC3);
        waitWr(w + 1);
        @(posedge iClk);
        #1 iTxWrFull = 1'b1;
        repeat (3) @(posedge iClk);
        #1 iTxWrFull = 1'b0;
        waitWr(w + 3);
        @(posedge iClk);
        #1 iTxWrFull = 1'b1;
        repeat (2) @(posedge iClk);
        #1 iTxWrFull = 1'b0;
        waitDone("bp");
        check("bp_cnt", 32'(oFrameCnt), 5);
        check("bp_len", 32'(wrCnt - w), 7);

        w = wrCnt;
        patQ = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        sendFrame(0, 3, 8'h3C, 8'h81, 8'hE7, 8'h00);
        waitDone("bubble");
        check("bubble_writes", 32'(wrCnt - w), 6);
        check("bubble_cnt", 32'(oFrameCnt), 6);

        w = wrCnt;
        fc = oFrameCnt;
        @(negedge iClk);
        pulse[1] = 1'b1;
        @(posedge iClk);
        #2 pulse[1] = 1'b0;
        repeat (2) @(negedge iClk);
        #1 check("wd_busy", 32'(oBusy), 1);
        repeat (4) @(negedge iClk);
        #1;
        check("wd_writes", 32'(wrCnt - w), 0);
        check("wd_cnt", 32'(oFrameCnt), 32'(fc));
        check("wd_idle", 32'(oBusy), 0);

        w = wrCnt;
        sendFrame(1, 4, 8'h10, 8'h20, 8'h30, 8'h40);
        waitWr(w + 3);
        #1 iRst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(oBusy), 0);
        check("mid_rst_wren", 32'(oTxWrEn), 0);
        check("mid_rst_ready", 32'(oReady), 0);
        check("mid_rst_data", 32'(oTxData), 0);
        check("mid_rst_cnt", 32'(oFrameCnt), 0);
        expQ.delete();
        srcQ1.delete();
        reqCnt[1] = grantSeen[1];
        repeat (2) @(negedge iClk);
        iRst = 1'b0;
        sendFrame(0, 2, 8'hAA, 8'h55, 8'h00, 8'h00);
        sendFrame(1, 2, 8'h12, 8'h34, 8'h00, 8'h00);
        waitDone("post_rst");
        check("post_rst_cnt", 32'(oFrameCnt), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
